// File: rtl/lzd_shift_normalizer.sv
//------------------------------------------------------------------------------
// Module      : lzd_shift_normalizer
// Description : Sequential left-normalizer: captures an operand, counts its
//               leading zeros and shifts it left one bit per cycle until the
//               MSB is set. Optional macro LZD_SHIFT_ZERO_BYPASS_EN skips the
//               shift cycles for an all-zero operand.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lzd_shift_normalizer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] shift_amt,
  output logic             zero
);

  localparam logic [CNT_W-1:0] c_width = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_opnd;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_lzd;

  logic [CNT_W-1:0] w_lzd;
  logic             w_in_zero;
  logic             w_lt;
  logic             w_do_shift;
  logic [CNT_W-1:0] w_final_amt;

  // Highest set bit wins, so scan upward and let later hits overwrite.
  always_comb begin
    w_lzd = c_width;
    for (int i = 0; i < WIDTH; i++) begin
      if (data_in[i]) begin
        w_lzd = CNT_W'(WIDTH - 1 - i);
      end
    end
  end

  assign w_in_zero = (data_in == '0);
  assign w_lt      = (r_cnt < r_lzd);

`ifdef LZD_SHIFT_ZERO_BYPASS_EN
  assign w_do_shift  = w_lt && !zero;
  assign w_final_amt = zero ? c_width : r_cnt;
`else
  assign w_do_shift  = w_lt;
  assign w_final_amt = r_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_opnd    <= '0;
      r_cnt     <= '0;
      r_lzd     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      shift_amt <= '0;
      zero      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_opnd  <= data_in;
            r_lzd   <= w_lzd;
            r_cnt   <= '0;
            zero    <= w_in_zero;
            busy    <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_do_shift) begin
            r_opnd <= {r_opnd[WIDTH-2:0], 1'b0};
            r_cnt  <= r_cnt + 1'b1;
          end else begin
            result    <= r_opnd;
            shift_amt <= w_final_amt;
            done      <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
